// File: rtl/gpu_pkg.sv
// Shared rendering-datapath types: sequencer FSM states, vertex array shapes and list strides.
package gpu_pkg;

    localparam int COORD_W      = 16;
    localparam int COLOR_W      = 16;
    localparam int VERTEX_BYTES = 6;

    typedef logic [2:0][2:0][COORD_W-1:0] vertex3_t;
    typedef logic [2:0][1:0][COORD_W-1:0] vertex2_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_VERT,
        ST_VERT_WAIT,
        ST_PIX,
        ST_PIX_WAIT
    } seq_state_t;

    // A triangle occupies three consecutive vertex records.
    function automatic int vertex_stride(input int vertex_size);
        return 3 * vertex_size;
    endfunction

    function automatic int color_stride(input int color_width);
        return color_width / 8;
    endfunction

    localparam int VERTEX_STRIDE = vertex_stride(VERTEX_BYTES);
    localparam int COLOR_STRIDE  = color_stride(COLOR_W);

endpackage

// File: rtl/render_addr_gen.sv
// Triangle index counter, vertex/colour address accumulators and last-triangle flag.
module render_addr_gen
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int V_STRIDE   = VERTEX_STRIDE,
    parameter int C_STRIDE   = COLOR_STRIDE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [31:0]           count,
    input  logic [ADDR_WIDTH-1:0] base_vertex,
    input  logic [ADDR_WIDTH-1:0] base_color,
    output logic [ADDR_WIDTH-1:0] addr_vertex,
    output logic [ADDR_WIDTH-1:0] addr_color,
    output logic                  last
);

    logic [31:0] index;
    logic [31:0] count_q;

    // Accumulators wrap naturally at 2^ADDR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            index       <= '0;
            count_q     <= '0;
            addr_vertex <= '0;
            addr_color  <= '0;
        end else if (load) begin
            index       <= '0;
            count_q     <= count;
            addr_vertex <= base_vertex;
            addr_color  <= base_color;
        end else if (advance) begin
            index       <= index + 32'd1;
            addr_vertex <= addr_vertex + ADDR_WIDTH'(V_STRIDE);
            addr_color  <= addr_color + ADDR_WIDTH'(C_STRIDE);
        end
    end

    assign last = (index == count_q - 32'd1);

endmodule

// File: rtl/render_sequencer.sv
// Per-frame triangle scheduler driving fetch, vertex and pixel stages in turn.
// Optional RENDER_SEQ_PERF_EN adds a saturating busy-cycle counter on frame_cycles.
module render_sequencer
    import gpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int COORD_WIDTH = 16,
    parameter int COLOR_WIDTH = 16,
    parameter int VERTEX_SIZE = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic [31:0]                      triangles_count,
    input  logic [ADDR_WIDTH-1:0]            base_addr_vertex,
    input  logic [ADDR_WIDTH-1:0]            base_addr_color,
    output logic                             busy,
    output logic                             frame_end,
    output logic                             fetch_start,
    output logic [ADDR_WIDTH-1:0]            curr_addr_vertex,
    output logic [ADDR_WIDTH-1:0]            curr_addr_color,
    input  logic [COLOR_WIDTH-1:0]           fetch_color,
    input  logic [2:0][2:0][COORD_WIDTH-1:0] fetch_vertexes,
    input  logic                             fetch_eoc,
    output logic                             ver_start,
    output logic [2:0][2:0][COORD_WIDTH-1:0] ver_vertexes,
    input  logic                             ver_eoc,
    input  logic [2:0][1:0][COORD_WIDTH-1:0] ver_vertexes_proj,
    input  logic [2:0][1:0][COORD_WIDTH-1:0] ver_normal_vectors,
    output logic                             pix_start,
    output logic [2:0][1:0][COORD_WIDTH-1:0] pix_vertexes_proj,
    output logic [2:0][1:0][COORD_WIDTH-1:0] pix_normal_vectors,
    output logic [COLOR_WIDTH-1:0]           pix_color,
    input  logic                             pix_eoc
`ifdef RENDER_SEQ_PERF_EN
    ,
    output logic [31:0]                      frame_cycles
`endif
);

    localparam int V_STRIDE = vertex_stride(VERTEX_SIZE);
    localparam int C_STRIDE = color_stride(COLOR_WIDTH);

    seq_state_t state, state_next;
    logic load, advance, end_next, cap_fetch, cap_ver, last;

    render_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .V_STRIDE   (V_STRIDE),
        .C_STRIDE   (C_STRIDE)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .advance     (advance),
        .count       (triangles_count),
        .base_vertex (base_addr_vertex),
        .base_color  (base_addr_color),
        .addr_vertex (curr_addr_vertex),
        .addr_color  (curr_addr_color),
        .last        (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Each eoc is honoured only in its own WAIT state, so issue-cycle eocs are dropped.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        end_next   = 1'b0;
        cap_fetch  = 1'b0;
        cap_ver    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    load = 1'b1;
                    if (triangles_count == 32'd0) end_next   = 1'b1;
                    else                          state_next = ST_FETCH;
                end
            end
            ST_FETCH:      state_next = ST_FETCH_WAIT;
            ST_FETCH_WAIT: begin
                if (fetch_eoc) begin
                    cap_fetch  = 1'b1;
                    state_next = ST_VERT;
                end
            end
            ST_VERT:       state_next = ST_VERT_WAIT;
            ST_VERT_WAIT: begin
                if (ver_eoc) begin
                    cap_ver    = 1'b1;
                    state_next = ST_PIX;
                end
            end
            ST_PIX:        state_next = ST_PIX_WAIT;
            ST_PIX_WAIT: begin
                if (pix_eoc) begin
                    if (last) begin
                        end_next   = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
            end
            default:       state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy               <= 1'b0;
            frame_end          <= 1'b0;
            fetch_start        <= 1'b0;
            ver_start          <= 1'b0;
            pix_start          <= 1'b0;
            ver_vertexes       <= '0;
            pix_color          <= '0;
            pix_vertexes_proj  <= '0;
            pix_normal_vectors <= '0;
        end else begin
            busy        <= (state_next != ST_IDLE);
            frame_end   <= end_next;
            fetch_start <= (state_next == ST_FETCH);
            ver_start   <= (state_next == ST_VERT);
            pix_start   <= (state_next == ST_PIX);
            if (cap_fetch) begin
                ver_vertexes <= fetch_vertexes;
                pix_color    <= fetch_color;
            end
            if (cap_ver) begin
                pix_vertexes_proj  <= ver_vertexes_proj;
                pix_normal_vectors <= ver_normal_vectors;
            end
        end
    end

`ifdef RENDER_SEQ_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || load) frame_cycles <= '0;
        else if (busy)   frame_cycles <= sat_inc(frame_cycles);
    end
`endif

endmodule

// File: tb/tb_render_sequencer.sv
// Directed-plus-random bench for render_sequencer with a transaction-level reference model.
module tb_render_sequencer;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, frame_start, fetch_eoc, ver_eoc, pix_eoc;
    logic [31:0] triangles_count, base_addr_vertex, base_addr_color;
    logic        busy, frame_end, fetch_start, ver_start, pix_start;
    logic [31:0] curr_addr_vertex, curr_addr_color;
    logic [15:0] fetch_color, pix_color;
    vertex3_t    fetch_vertexes, ver_vertexes;
    vertex2_t    ver_vertexes_proj, ver_normal_vectors, pix_vertexes_proj, pix_normal_vectors;
`ifdef RENDER_SEQ_PERF_EN
    logic [31:0] frame_cycles;
`endif

    int n_vec = 0, n_miss = 0;
    int n_busy, n_fs, n_vs, n_ps, n_fe;

    always #5 clk = ~clk;

    render_sequencer dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .triangles_count(triangles_count),
        .base_addr_vertex(base_addr_vertex), .base_addr_color(base_addr_color),
        .busy(busy), .frame_end(frame_end), .fetch_start(fetch_start),
        .curr_addr_vertex(curr_addr_vertex), .curr_addr_color(curr_addr_color),
        .fetch_color(fetch_color), .fetch_vertexes(fetch_vertexes), .fetch_eoc(fetch_eoc),
        .ver_start(ver_start), .ver_vertexes(ver_vertexes), .ver_eoc(ver_eoc),
        .ver_vertexes_proj(ver_vertexes_proj), .ver_normal_vectors(ver_normal_vectors),
        .pix_start(pix_start), .pix_vertexes_proj(pix_vertexes_proj),
        .pix_normal_vectors(pix_normal_vectors), .pix_color(pix_color), .pix_eoc(pix_eoc)
`ifdef RENDER_SEQ_PERF_EN
        , .frame_cycles(frame_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are observed at the falling edge and pulses tallied.
    task automatic tick();
        @(negedge clk);
        if (busy)        n_busy++;
        if (fetch_start) n_fs++;
        if (ver_start)   n_vs++;
        if (pix_start)   n_ps++;
        if (frame_end)   n_fe++;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic vertex3_t rand_v3();
        vertex3_t v;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) v[a][b] = 16'($urandom);
        return v;
    endfunction

    function automatic vertex2_t rand_v2();
        vertex2_t v;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 2; b++) v[a][b] = 16'($urandom);
        return v;
    endfunction

    // Reference: triangle i lives at base + i*stride (mod 2^32); each stage result
    // appears one cycle after its eoc; the frame ends one cycle after the last pix_eoc.
    task automatic run_frame(input int cnt, input logic [31:0] bv, input logic [31:0] bc,
                             input bit spur, input int abort_at);
        vertex3_t fv;
        vertex2_t pv, nv;
        logic [15:0] fc;
        logic [31:0] ev, ec;
        n_busy = 0; n_fs = 0; n_vs = 0; n_ps = 0; n_fe = 0;
        triangles_count  = 32'(cnt);
        base_addr_vertex = bv;
        base_addr_color  = bc;
        frame_start      = 1'b1;
        tick();
        frame_start = 1'b0;
        if (cnt == 0) begin
            chk("zero_frame_end", 160'(frame_end), 160'(1));
            chk("zero_busy", 160'(busy), 160'(0));
            tick();
            chk("zero_no_starts", 160'(n_fs + n_vs + n_ps + n_busy), 160'(0));
`ifdef RENDER_SEQ_PERF_EN
            chk("zero_frame_cycles", 160'(frame_cycles), 160'(0));
`endif
            return;
        end
        for (int i = 0; i < cnt; i++) begin
            ev = bv + 32'(i) * 32'd18;
            ec = bc + 32'(i) * 32'd2;
            chk("fetch_start", 160'(fetch_start), 160'(1));
            chk("busy", 160'(busy), 160'(1));
            chk("addr_vertex", 160'(curr_addr_vertex), 160'(ev));
            chk("addr_color", 160'(curr_addr_color), 160'(ec));
            if (spur) begin
                fetch_eoc = 1'b1; frame_start = 1'b1; triangles_count = 32'd99;
            end
            tick();
            fetch_eoc = 1'b0; frame_start = 1'b0;
            chk("fetch_pulse_len", 160'(fetch_start), 160'(0));
            chk("no_early_ver", 160'(ver_start), 160'(0));
            idle_cycles($urandom_range(0, 4));
            fv = rand_v3(); fc = 16'($urandom);
            fetch_vertexes = fv; fetch_color = fc; fetch_eoc = 1'b1;
            tick();
            fetch_eoc = 1'b0; fetch_vertexes = rand_v3(); fetch_color = 16'($urandom);
            chk("ver_start", 160'(ver_start), 160'(1));
            chk("ver_vertexes", 160'(ver_vertexes), 160'(fv));
            chk("pix_color_cap", 160'(pix_color), 160'(fc));
            chk("addr_stable", 160'(curr_addr_vertex), 160'(ev));
            tick();
            if (spur) begin
                fetch_eoc = 1'b1; frame_start = 1'b1;
                tick();
                fetch_eoc = 1'b0; frame_start = 1'b0;
                chk("spur_ver_hold", 160'(ver_vertexes), 160'(fv));
                chk("spur_no_pix", 160'(pix_start), 160'(0));
            end
            idle_cycles($urandom_range(0, 4));
            pv = rand_v2(); nv = rand_v2();
            ver_vertexes_proj = pv; ver_normal_vectors = nv; ver_eoc = 1'b1;
            tick();
            ver_eoc = 1'b0; ver_vertexes_proj = rand_v2(); ver_normal_vectors = rand_v2();
            chk("pix_start", 160'(pix_start), 160'(1));
            chk("pix_proj", 160'(pix_vertexes_proj), 160'(pv));
            chk("pix_norm", 160'(pix_normal_vectors), 160'(nv));
            chk("pix_color", 160'(pix_color), 160'(fc));
            tick();
            if (i == abort_at) return;
            idle_cycles($urandom_range(0, 4));
            pix_eoc = 1'b1;
            tick();
            pix_eoc = 1'b0;
        end
        chk("frame_end", 160'(frame_end), 160'(1));
        chk("busy_end", 160'(busy), 160'(0));
        chk("n_fetch", 160'(n_fs), 160'(cnt));
        chk("n_ver", 160'(n_vs), 160'(cnt));
        chk("n_pix", 160'(n_ps), 160'(cnt));
        chk("n_frame_end", 160'(n_fe), 160'(1));
`ifdef RENDER_SEQ_PERF_EN
        chk("frame_cycles", 160'(frame_cycles), 160'(n_busy));
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 160'({busy, frame_end, fetch_start, ver_start, pix_start}), 160'(0));
        chk({tag, "_addr"}, 160'({curr_addr_vertex, curr_addr_color}), 160'(0));
        chk({tag, "_ver"}, 160'(ver_vertexes), 160'(0));
        chk({tag, "_pix"}, 160'({pix_vertexes_proj, pix_normal_vectors, pix_color}), 160'(0));
`ifdef RENDER_SEQ_PERF_EN
        chk({tag, "_cycles"}, 160'(frame_cycles), 160'(0));
`endif
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; fetch_eoc = 1'b0; ver_eoc = 1'b0; pix_eoc = 1'b0;
        triangles_count = '0; base_addr_vertex = '0; base_addr_color = '0;
        fetch_color = '0; fetch_vertexes = '0; ver_vertexes_proj = '0; ver_normal_vectors = '0;
        idle_cycles(2);
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        run_frame(1, 32'h0000_1000, 32'h0000_2000, 1'b0, -1);
        run_frame(3, 32'h0000_1000, 32'h0000_2000, 1'b0, -1);
        run_frame(0, 32'h0000_1000, 32'h0000_2000, 1'b0, -1);
        run_frame(2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0, -1);
        run_frame(2, 32'h0000_3000, 32'h0000_4000, 1'b1, -1);

        run_frame(2, 32'h0000_5000, 32'h0000_6000, 1'b0, 0);
        pix_eoc = 1'b1; rst = 1'b1;
        tick();
        pix_eoc = 1'b0; rst = 1'b0;
        chk_all_zero("midframe_reset");
        tick();
        chk("post_reset_idle", 160'({busy, fetch_start, frame_end}), 160'(0));

        run_frame(2, 32'h0000_7000, 32'h0000_8000, 1'b0, -1);
        for (int f = 0; f < 6; f++)
            run_frame(int'($urandom_range(0, 4)), $urandom, $urandom, 1'($urandom_range(0, 1)), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/render_sequencer.md
# render_sequencer

Per-frame triangle scheduler for the rendering datapath. On a `frame_start` pulse it latches the frame descriptor (triangle count, vertex and colour base addresses). It then walks the triangle list one triangle at a time through three stages: `data_fetch`, `vertex_computation` and `pixel_computation`. It generates each stage's start pulse and operands, and registers each stage's results as operands for the next stage. It sits between the AXI register target and the three stage instances and signals `frame_end` when the list is exhausted.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, memory address width
- `COORD_WIDTH`, 16, coordinate width
- `COLOR_WIDTH`, 16, colour width; multiple of 8
- `VERTEX_SIZE`, 6, bytes per vertex; triangle stride is 3*VERTEX_SIZE

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `frame_start`  in  1  one-cycle request to render a frame
- `triangles_count`  in  32  triangles in frame
- `base_addr_vertex`, `base_addr_color`  in  ADDR_WIDTH  list bases
- `busy`  out  1  frame in progress
- `frame_end`  out  1  one-cycle completion pulse
- `fetch_start`  out  1  fetch start pulse
- `curr_addr_vertex`, `curr_addr_color`  out  ADDR_WIDTH  current triangle addresses
- `fetch_color`  in  COLOR_WIDTH; `fetch_vertexes`  in  [3][3]xCOORD_WIDTH; `fetch_eoc`  in  1
- `ver_start`  out  1; `ver_vertexes`  out  [3][3]xCOORD_WIDTH; `ver_eoc`  in  1
- `ver_vertexes_proj`  in  [3][2]xCOORD_WIDTH; `ver_normal_vectors`  in  [3][2]xCOORD_WIDTH
- `pix_start`  out  1; `pix_vertexes_proj`, `pix_normal_vectors`  out  [3][2]xCOORD_WIDTH
- `pix_color`  out  COLOR_WIDTH; `pix_eoc`  in  1

## Operation
- FSM states:
  - `IDLE`
  - `FETCH`: `fetch_start`=1, held 1 cycle
  - `FETCH_WAIT`
  - `VERT`: `ver_start`=1
  - `VERT_WAIT`
  - `PIX`: `pix_start`=1
  - `PIX_WAIT`
- `IDLE` + `frame_start`:
  - Latch the descriptor and set index=0.
  - If count=0, pulse `frame_end` and stay in `IDLE`.
  - Otherwise go to `FETCH`.
- `FETCH_WAIT` + `fetch_eoc`: register `fetch_vertexes` into `ver_vertexes` and `fetch_color` into `pix_color`; go to `VERT`.
- `VERT_WAIT` + `ver_eoc`: register projections and normals into the `pix_*` outputs; go to `PIX`.
- `PIX_WAIT` + `pix_eoc`:
  - If this was the last triangle, pulse `frame_end` and go to `IDLE`.
  - Otherwise advance the addresses and go to `FETCH`.
- Address update:
  - Vertex address += 3*VERTEX_SIZE.
  - Colour address += COLOR_WIDTH/8.
  - Both are accumulators that wrap modulo 2^ADDR_WIDTH (no multiplier).
- Triangle index is 32-bit; last triangle is index == latched count-1.
- Ignored inputs:
  - `frame_start` outside `IDLE`, and descriptor changes mid-frame.
  - An `*_eoc` outside its own WAIT state, including in the issue cycle.
- Output stability: addresses stable from `FETCH` until `fetch_eoc`; `ver_vertexes` and `pix_*` stable until recaptured.
- Reset (including mid-frame): go to `IDLE`; every output and register is 0; in-flight stage results are discarded.

## Timing
- All outputs are registered.
- Count > 0:
  - `frame_start` at cycle t: `busy`=1 and `fetch_start`=1 at t+1, with addresses equal to the bases.
  - `fetch_eoc` at u: `ver_start`=1 and `ver_vertexes` valid at u+1.
  - `ver_eoc` at v: `pix_start`=1 and `pix_*` valid at v+1.
  - `pix_eoc` at w, not last: `fetch_start` for the next triangle at w+1.
  - `pix_eoc` at w, last: `frame_end`=1 and `busy`=0 at w+1.
- Count = 0: `frame_end`=1 at t+1; `busy` stays 0.
- Overhead is 3 cycles per triangle beyond stage latencies.
- A new `frame_start` is accepted in the same cycle `frame_end` is high.

## Configuration
- `RENDER_SEQ_PERF_EN` defined:
  - Adds output `frame_cycles` [31:0], reset 0.
  - Counts cycles while `busy`=1, saturating at 2^32-1.
  - Cleared on frame acceptance; holds its value after `frame_end`.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `gpu_pkg`:
  - FSM state enum.
  - Array typedefs `vertex3_t` ([3][3]) and `vertex2_t` ([3][2]).
  - Stride constants derived from `VERTEX_SIZE`/`COLOR_WIDTH`.
- One natural sub-module, `render_addr_gen`: index counter, both address accumulators and the last-triangle flag.

## Test plan
- Count=1, bases 0x1000/0x2000, each stage eoc 5 cycles after start:
  - `fetch_start` at t+1 with 0x1000/0x2000.
  - `ver_start` and `pix_start` follow, each one cycle after the preceding eoc.
  - `frame_end` one cycle after `pix_eoc`.
- Count=3: fetch addresses 0x1000, 0x1012, 0x1024 and 0x2000, 0x2002, 0x2004; exactly 3 of each start pulse; one `frame_end`.
- Count=0: `frame_end` at t+1; no start pulses; `busy` stays 0.
- Base vertex 0xFFFFFFF0, count=2: second address 0x00000002 (wrap).
- Spurious `fetch_eoc` during `VERT_WAIT` and `frame_start` mid-frame: no state change; frame completes normally.
- `rst` asserted during `PIX_WAIT`: all outputs 0 next cycle; a following frame runs correctly. With `RENDER_SEQ_PERF_EN`, `frame_cycles` equals the measured busy length.
